// File: rtl/mil_pkg.sv
// mil_pkg: shared types and constants for the MIL-STD-1553B bus-channel manager.
//   mil_sw_state_t : channel-manager FSM state encoding
//   MIL_LINE_IDLE  : line-pair value of a quiet bus
package mil_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLock = 2'd1,
    StTx   = 2'd2,
    StHold = 2'd3
  } mil_sw_state_t;

  localparam logic [1:0] MIL_LINE_IDLE = 2'b00;

endpackage

// File: rtl/mil_prio_enc.sv
// mil_prio_enc: lowest-index priority encoder.
//   iReq   in  NUM_CH  request vector
//   oIdx   out CW      index of the lowest set bit (0 when none)
//   oValid out 1       at least one request bit set
module mil_prio_enc #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CW     = 1
) (
  input  logic [NUM_CH-1:0] iReq,
  output logic [CW-1:0]     oIdx,
  output logic              oValid
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    oIdx   = '0;
    oValid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (iReq[k]) begin
        oIdx   = CW'(k);
        oValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mil_bus_switch.sv
// mil_bus_switch: MIL-STD-1553B bus-channel manager between NUM_CH redundant
// transceiver channels and one shared receiver/transmitter core.
//   iCLK         in  1         clock (codec core domain)
//   iRESET_N     in  1         asynchronous active-low reset
//   iCH_EN       in  NUM_CH    per-channel enable mask
//   iDI          in  2*NUM_CH  line inputs, channel k at [2k+1:2k]
//   oDO          out 2*NUM_CH  line outputs, same packing
//   oRX_STROB    out NUM_CH    1 = channel receiver enabled
//   oTX_INHIBIT  out NUM_CH    1 = channel transmitter inhibited
//   oDI          out 2         merged line to the shared receiver
//   iDO          in  2         line data from the shared transmitter
//   iTX_BUSY     in  1         shared transmitter busy
//   oLOCKED      out 1         receive path locked to one channel
//   oACTIVE_CH   out CW        selected channel index
module mil_bus_switch
  import mil_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned SILENCE_CYCLES = 24,
  parameter int unsigned HOLD_CYCLES    = 5,
  localparam int unsigned CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                iCLK,
  input  logic                iRESET_N,
  input  logic [NUM_CH-1:0]   iCH_EN,
  input  logic [2*NUM_CH-1:0] iDI,
  output logic [2*NUM_CH-1:0] oDO,
  output logic [NUM_CH-1:0]   oRX_STROB,
  output logic [NUM_CH-1:0]   oTX_INHIBIT,
  output logic [1:0]          oDI,
  input  logic [1:0]          iDO,
  input  logic                iTX_BUSY,
  output logic                oLOCKED,
  output logic [CW-1:0]       oACTIVE_CH
);

  localparam int unsigned SW = $clog2(SILENCE_CYCLES);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] SilLast  = SW'(SILENCE_CYCLES - 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);

  mil_sw_state_t     stateQ;
  logic [CW-1:0]     selQ;
  logic [SW-1:0]     silCntQ;
  logic [HW-1:0]     holdCntQ;
  logic [NUM_CH-1:0] rxStrobQ;
  logic [NUM_CH-1:0] txInhQ;
  logic              lockedQ;

  logic [NUM_CH-1:0] chAct;
  logic [CW-1:0]     actIdx;
  logic              actValid;
  logic [CW-1:0]     enIdx;
  logic              enValid;
  logic              selEn;
  logic [1:0]        selPair;
  logic              window;

  always_comb begin
    chAct = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chAct[k] = iCH_EN[k] & (iDI[2*k+1] | iDI[2*k]);
    end
  end

  mil_prio_enc #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_act_enc (
    .iReq   (chAct),
    .oIdx   (actIdx),
    .oValid (actValid)
  );

  mil_prio_enc #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_en_enc (
    .iReq   (iCH_EN),
    .oIdx   (enIdx),
    .oValid (enValid)
  );

  assign selEn   = iCH_EN[selQ];
  assign selPair = iDI[{selQ, 1'b0} +: 2];
  assign window  = (stateQ == StTx) || (stateQ == StHold);

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      stateQ   <= StIdle;
      selQ     <= '0;
      silCntQ  <= '0;
      holdCntQ <= '0;
      rxStrobQ <= '1;
      txInhQ   <= '1;
      lockedQ  <= 1'b0;
    end else begin
      // Strobe/inhibit follow the current state, so they lag a transition by one cycle.
      rxStrobQ <= iCH_EN & {NUM_CH{~window}};
      for (int k = 0; k < NUM_CH; k++) begin
        txInhQ[k] <= ~(window & (selQ == CW'(k)) & iCH_EN[k]);
      end

      case (stateQ)
        StIdle: begin
          // Incoming traffic wins over a pending transmit; LOCK hands over to TX next cycle.
          if (actValid) begin
            stateQ  <= StLock;
            selQ    <= actIdx;
            silCntQ <= '0;
            lockedQ <= 1'b1;
          end else if (iTX_BUSY) begin
            stateQ  <= StTx;
            lockedQ <= 1'b1;
            if (!selEn) selQ <= enValid ? enIdx : '0;
          end
        end
        StLock: begin
          if (iTX_BUSY) begin
            stateQ <= StTx;
          end else if (!selEn) begin
            stateQ  <= StIdle;
            silCntQ <= '0;
            lockedQ <= 1'b0;
          end else if (chAct[selQ]) begin
            silCntQ <= '0;
          end else if (silCntQ == SilLast) begin
            stateQ  <= StIdle;
            silCntQ <= '0;
            lockedQ <= 1'b0;
          end else begin
            silCntQ <= silCntQ + 1'b1;
          end
        end
        StTx: begin
          if (!iTX_BUSY) begin
            stateQ   <= StHold;
            holdCntQ <= '0;
          end
        end
        StHold: begin
          if (iTX_BUSY) begin
            stateQ <= StTx;
          end else if (holdCntQ == HoldLast) begin
            stateQ  <= StLock;
            silCntQ <= '0;
          end else begin
            holdCntQ <= holdCntQ + 1'b1;
          end
        end
        default: begin
          stateQ  <= StIdle;
          lockedQ <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency data path: merge in IDLE, selected pair otherwise.
  always_comb begin
    oDI = MIL_LINE_IDLE;
    if (stateQ == StIdle) begin
      for (int k = 0; k < NUM_CH; k++) begin
        oDI = oDI | (iDI[2*k +: 2] & {2{iCH_EN[k]}});
      end
    end else begin
      oDI = selPair;
    end
  end

  always_comb begin
    oDO = {NUM_CH{MIL_LINE_IDLE}};
    if (window) oDO[{selQ, 1'b0} +: 2] = iDO & {2{selEn}};
  end

  assign oRX_STROB   = rxStrobQ;
  assign oTX_INHIBIT = txInhQ;
  assign oLOCKED     = lockedQ;
  assign oACTIVE_CH  = selQ;

endmodule

// File: tb/tb_mil_bus_switch.sv
// Self-checking bench for mil_bus_switch (NUM_CH=4): directed scenarios plus
// randomized traffic, all outputs compared against a behavioural model.
module tb_mil_bus_switch;

  localparam int NCH = 4;
  localparam int SIL = 24;
  localparam int HLD = 5;

  logic             iCLK = 1'b0;
  logic             iRESET_N;
  logic [NCH-1:0]   chEn;
  logic [2*NCH-1:0] lineIn;
  logic [2*NCH-1:0] lineOut;
  logic [NCH-1:0]   rxStrob;
  logic [NCH-1:0]   txInh;
  logic [1:0]       mergedDi;
  logic [1:0]       coreDo;
  logic             txBusy;
  logic             locked;
  logic [1:0]       activeCh;

  int total = 0;
  int bad   = 0;

  // Behavioural model: 0=idle 1=locked 2=transmitting 3=post-transmit hold
  int             mState;
  int             mSel;
  int             mSil;
  int             mHold;
  logic [NCH-1:0] mStrob;
  logic [NCH-1:0] mInh;
  logic           mLocked;

  always #5 iCLK = ~iCLK;

  mil_bus_switch #(
    .NUM_CH         (NCH),
    .SILENCE_CYCLES (SIL),
    .HOLD_CYCLES    (HLD)
  ) dut (
    .iCLK        (iCLK),
    .iRESET_N    (iRESET_N),
    .iCH_EN      (chEn),
    .iDI         (lineIn),
    .oDO         (lineOut),
    .oRX_STROB   (rxStrob),
    .oTX_INHIBIT (txInh),
    .oDI         (mergedDi),
    .iDO         (coreDo),
    .iTX_BUSY    (txBusy),
    .oLOCKED     (locked),
    .oACTIVE_CH  (activeCh)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic int lowest(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mState  = 0;
    mSel    = 0;
    mSil    = 0;
    mHold   = 0;
    mStrob  = '1;
    mInh    = '1;
    mLocked = 1'b0;
  endtask

  task automatic modelStep();
    logic [NCH-1:0] act;
    bit             win;
    int             lo;
    for (int k = 0; k < NCH; k++) act[k] = chEn[k] && (lineIn[2*k +: 2] != 2'b00);
    win = (mState >= 2);
    mStrob = win ? '0 : chEn;
    for (int k = 0; k < NCH; k++) mInh[k] = !(win && (k == mSel) && chEn[k]);
    if (mState == 0) begin
      lo = lowest(act);
      if (lo >= 0) begin
        mState = 1; mSel = lo; mSil = 0;
      end else if (txBusy) begin
        mState = 2;
        if (!chEn[mSel]) begin
          lo = lowest(chEn);
          mSel = (lo >= 0) ? lo : 0;
        end
      end
    end else if (mState == 1) begin
      if (txBusy) mState = 2;
      else if (!chEn[mSel]) begin mState = 0; mSil = 0; end
      else if (act[mSel]) mSil = 0;
      else if (mSil == SIL - 1) begin mState = 0; mSil = 0; end
      else mSil++;
    end else if (mState == 2) begin
      if (!txBusy) begin mState = 3; mHold = 0; end
    end else begin
      if (txBusy) mState = 2;
      else if (mHold == HLD - 1) begin mState = 1; mSil = 0; end
      else mHold++;
    end
    mLocked = (mState != 0);
  endtask

  task automatic checkComb(input string tag);
    logic [1:0]       expDi;
    logic [2*NCH-1:0] expDo;
    expDi = 2'b00;
    if (mState == 0) begin
      for (int k = 0; k < NCH; k++) if (chEn[k]) expDi = expDi | lineIn[2*k +: 2];
    end else begin
      expDi = lineIn[2*mSel +: 2];
    end
    expDo = '0;
    if (mState >= 2 && chEn[mSel]) expDo[2*mSel +: 2] = coreDo;
    checkVal({tag, "_oDI"}, 32'(mergedDi), 32'(expDi));
    checkVal({tag, "_oDO"}, 32'(lineOut), 32'(expDo));
  endtask

  task automatic checkRegs(input string tag);
    checkVal({tag, "_strob"}, 32'(rxStrob), 32'(mStrob));
    checkVal({tag, "_inhibit"}, 32'(txInh), 32'(mInh));
    checkVal({tag, "_locked"}, 32'(locked), 32'(mLocked));
    checkVal({tag, "_activeCh"}, 32'(activeCh), mSel);
  endtask

  // One clock cycle starting and ending at a falling edge.
  task automatic cyc(input string tag, input logic [NCH-1:0] en, input logic [2*NCH-1:0] di,
                     input logic busy, input logic [1:0] dIn);
    chEn   = en;
    lineIn = di;
    txBusy = busy;
    coreDo = dIn;
    #1;
    checkComb(tag);
    @(posedge iCLK);
    modelStep();
    @(negedge iCLK);
    checkRegs(tag);
  endtask

  task automatic doReset();
    iRESET_N = 1'b0;
    #1;
    modelReset();
    checkRegs("rst");
    checkComb("rst");
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRESET_N = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0]   rEn;
    logic [2*NCH-1:0] rDi;
    logic             rBusy;
    int               burst;
    int               burstCh;
    logic [1:0]       burstVal;

    iRESET_N = 1'b0;
    chEn     = 4'b0011;
    lineIn   = '0;
    txBusy   = 1'b0;
    coreDo   = 2'b00;
    @(negedge iCLK);
    doReset();
    checkVal("rst_strob_all1", 32'(rxStrob), 32'hF);

    // Lock on ch1, ch0 ignored, then silence timeout.
    repeat (3) cyc("lock1", 4'b0011, 8'b0000_1000, 1'b0, 2'b00);
    checkVal("lock1_locked", 32'(locked), 32'd1);
    checkVal("lock1_ch", 32'(activeCh), 32'd1);
    cyc("ign0", 4'b0011, 8'b0000_0001, 1'b0, 2'b00);
    checkVal("ign0_oDI", 32'(mergedDi), 32'd0);
    repeat (22) cyc("sil", 4'b0011, 8'b0, 1'b0, 2'b00);
    checkVal("sil23_locked", 32'(locked), 32'd1);
    cyc("sil", 4'b0011, 8'b0, 1'b0, 2'b00);
    checkVal("sil24_unlocked", 32'(locked), 32'd0);

    // Lock on ch0 then transmit 20 cycles.
    cyc("lock0", 4'b0011, 8'b0000_0001, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) cyc("tx", 4'b0011, 8'b0, 1'b1, i[0] ? 2'b10 : 2'b01);
    checkVal("tx_inhibit", 32'(txInh), 32'hE);
    checkVal("tx_strob", 32'(rxStrob), 32'h0);
    checkVal("tx_oDO", 32'(lineOut), 32'h2);
    for (int i = 0; i < 8; i++) cyc("hold", 4'b0011, 8'b0, 1'b0, 2'b11);
    checkVal("hold_locked", 32'(locked), 32'd1);
    checkVal("hold_strob", 32'(rxStrob), 32'h3);

    // Simultaneous activity: lowest index wins.
    doReset();
    cyc("simul", 4'b1111, 8'b0000_1001, 1'b0, 2'b00);
    checkVal("simul_ch", 32'(activeCh), 32'd0);

    // Disable the locked channel.
    doReset();
    cyc("dis", 4'b0011, 8'b0000_0100, 1'b0, 2'b00);
    cyc("dis", 4'b0001, 8'b0000_0100, 1'b0, 2'b00);
    checkVal("dis_unlocked", 32'(locked), 32'd0);

    // Disable the selected channel mid-transmit.
    doReset();
    cyc("distx", 4'b0011, 8'b0000_0100, 1'b0, 2'b00);
    repeat (3) cyc("distx", 4'b0011, 8'b0, 1'b1, 2'b11);
    repeat (3) cyc("distx", 4'b0001, 8'b0, 1'b1, 2'b11);
    checkVal("distx_oDO", 32'(lineOut), 32'h0);
    checkVal("distx_locked", 32'(locked), 32'd1);
    repeat (8) cyc("distx", 4'b0001, 8'b0, 1'b0, 2'b00);

    // Reset asserted mid-transmit.
    cyc("rsttx", 4'b0011, 8'b0000_0001, 1'b0, 2'b00);
    repeat (3) cyc("rsttx", 4'b0011, 8'b0, 1'b1, 2'b11);
    #2;
    iRESET_N = 1'b0;
    #1;
    modelReset();
    checkVal("rsttx_oDO", 32'(lineOut), 32'h0);
    checkVal("rsttx_strob", 32'(rxStrob), 32'hF);
    checkVal("rsttx_inhibit", 32'(txInh), 32'hF);
    checkVal("rsttx_locked", 32'(locked), 32'd0);
    checkVal("rsttx_ch", 32'(activeCh), 32'd0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRESET_N = 1'b1;
    cyc("rsttx_after", 4'b0011, 8'b0, 1'b0, 2'b00);

    // Randomized traffic.
    rEn   = 4'b1111;
    rBusy = 1'b0;
    burst = 0;
    burstCh = 0;
    burstVal = 2'b01;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) rEn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 127) == 0) rEn = 4'b1111;
      if ($urandom_range(0, 15) == 0) rBusy = ~rBusy;
      rDi = '0;
      if (burst > 0) begin
        burst--;
        rDi[2*burstCh +: 2] = burstVal;
      end else if ($urandom_range(0, 39) == 0) begin
        burst    = $urandom_range(1, 6);
        burstCh  = $urandom_range(0, NCH - 1);
        burstVal = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 19) == 0) rDi[2*$urandom_range(0, NCH - 1) +: 2] = 2'($urandom);
      cyc("rnd", rEn, rDi, rBusy, 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
